// File: rtl/ldst_queue_ctrl_pkg.sv
// Shared types and constants for the four-entry collapsing LDST issue queue.
// LDST_WIDTH is a global macro; this file provides a default when it is not set.
`ifndef LDST_WIDTH
`define LDST_WIDTH 16
`endif

package ldst_pkg;
    localparam int LDST_DEPTH = 4;
    localparam int LDST_W     = `LDST_WIDTH;

    typedef logic [1:0]        slot_idx_t;
    typedef logic [2:0]        cnt_t;
    typedef logic [LDST_W-1:0] ldst_data_t;
endpackage

// File: rtl/ldst_queue_ctrl_if.sv
// Enqueue/issue handshake bundle between upstream, the queue and the LSU.
// master = upstream/LSU side driving requests; slave = the queue itself.
interface ldst_queue_ctrl_if;
    import ldst_pkg::*;

    logic       enq_valid;
    logic       enq_ready;
    ldst_data_t enq_data;
    logic       enq_rdy;
    logic       iss_valid;
    logic       iss_ready;
    ldst_data_t iss_data;
    slot_idx_t  iss_slot;

    modport master (
        output enq_valid, enq_data, enq_rdy, iss_ready,
        input  enq_ready, iss_valid, iss_data, iss_slot
    );

    modport slave (
        input  enq_valid, enq_data, enq_rdy, iss_ready,
        output enq_ready, iss_valid, iss_data, iss_slot
    );
endinterface

// File: rtl/ldst_queue_ctrl_yasuo.sv
// Compaction stage: slot i takes slot i+1 when issu_i is set; slot 3 takes data_out.
module yasuo
    import ldst_pkg::*;
(
    input  logic       issu_a,
    input  logic       issu_b,
    input  logic       issu_c,
    input  logic       issu_d,
    input  ldst_data_t data_out,
    input  ldst_data_t i_slot_a,
    input  ldst_data_t i_slot_b,
    input  ldst_data_t i_slot_c,
    input  ldst_data_t i_slot_d,
    output ldst_data_t o_slot_a,
    output ldst_data_t o_slot_b,
    output ldst_data_t o_slot_c,
    output ldst_data_t o_slot_d
);
    assign o_slot_a = issu_a ? i_slot_b : i_slot_a;
    assign o_slot_b = issu_b ? i_slot_c : i_slot_b;
    assign o_slot_c = issu_c ? i_slot_d : i_slot_c;
    assign o_slot_d = issu_d ? data_out : i_slot_d;
endmodule

// File: rtl/ldst_queue_ctrl.sv
// Four-entry collapsing load/store issue queue: oldest-ready select, hole compaction via yasuo.
// Optional same-cycle bypass of an empty queue is enabled by defining LDST_BYPASS_EN.
module ldst_queue_ctrl
    import ldst_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        entry_rdy,
    output cnt_t              count,
    ldst_queue_ctrl_if.slave  bus
);
    logic [3:0] r_valid;
    ldst_data_t r_slot [LDST_DEPTH];
    cnt_t       r_count;

    logic [3:0] w_cand;
    logic       w_sel_valid;
    slot_idx_t  w_sel_k;
    logic       w_byp;
    logic       w_iss_fire;
    logic       w_byp_fire;
    logic       w_enq_fire;
    logic [3:0] w_issu;
    ldst_data_t w_shift [LDST_DEPTH];
    cnt_t       w_wr_idx;
    cnt_t       w_count_next;

    // Oldest ready entry wins: scan from youngest down so the lowest index sticks.
    always_comb begin
        w_cand      = r_valid & entry_rdy;
        w_sel_valid = |w_cand;
        w_sel_k     = '0;
        for (int i = LDST_DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) w_sel_k = slot_idx_t'(i);
        end
    end

`ifdef LDST_BYPASS_EN
    assign w_byp = !rst && (r_count == '0) && bus.enq_valid && bus.enq_rdy;
`else
    logic unused_enq_rdy;
    assign unused_enq_rdy = bus.enq_rdy;
    assign w_byp          = 1'b0;
`endif

    assign bus.iss_valid = !rst && (w_sel_valid || w_byp);
    assign bus.iss_data  = rst         ? '0 :
                           w_byp       ? bus.enq_data :
                           w_sel_valid ? r_slot[w_sel_k] : '0;
    assign bus.iss_slot  = (!rst && w_sel_valid) ? w_sel_k : '0;
    assign bus.enq_ready = !rst && (r_count != cnt_t'(LDST_DEPTH));

    assign w_iss_fire = !rst && w_sel_valid && bus.iss_ready;
    assign w_byp_fire = w_byp && bus.iss_ready;
    assign w_enq_fire = bus.enq_valid && bus.enq_ready && !w_byp_fire;

    assign w_wr_idx     = r_count - cnt_t'(w_iss_fire);
    assign w_count_next = w_wr_idx + cnt_t'(w_enq_fire);
    assign count        = r_count;

    generate
        for (genvar gi = 0; gi < LDST_DEPTH; gi++) begin : g_issu
            assign w_issu[gi] = w_iss_fire && (slot_idx_t'(gi) >= w_sel_k);
        end
    endgenerate

    yasuo u_yasuo (
        .issu_a   (w_issu[0]),
        .issu_b   (w_issu[1]),
        .issu_c   (w_issu[2]),
        .issu_d   (w_issu[3]),
        .data_out ('0),
        .i_slot_a (r_slot[0]),
        .i_slot_b (r_slot[1]),
        .i_slot_c (r_slot[2]),
        .i_slot_d (r_slot[3]),
        .o_slot_a (w_shift[0]),
        .o_slot_b (w_shift[1]),
        .o_slot_c (w_shift[2]),
        .o_slot_d (w_shift[3])
    );

    // Enqueue lands in the first free slot after compaction; flush freezes payloads.
    generate
        for (genvar gi = 0; gi < LDST_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_slot[gi] <= '0;
                end else if (!flush) begin
                    if (w_enq_fire && (w_wr_idx == cnt_t'(gi)))
                        r_slot[gi] <= bus.enq_data;
                    else
                        r_slot[gi] <= w_shift[gi];
                end
            end
        end
    endgenerate

    // Entries stay contiguous from slot 0, so the valid mask follows the count.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_count <= w_count_next;
            for (int i = 0; i < LDST_DEPTH; i++)
                r_valid[i] <= (cnt_t'(i) < w_count_next);
        end
    end
endmodule
